// File: rtl/bcd_disp_mux.sv
// bcd_disp_mux: latches three BCD digits from the binary-to-BCD converter and
// scans them onto a 3-digit common-anode 7-segment display. Each digit slot is
// REFRESH_DIV cycles long and starts with GUARD cycles of all anodes off, so
// the previous digit's segment pattern never ghosts onto the next anode.
// Leading zeros can optionally be blanked; digits above 9 show a dash.
// All display outputs are registered and are computed from the pre-edge
// counter, index and latched digits, so they trail that state by one cycle.

module bcd_disp_mux #(
  parameter int REFRESH_DIV = 50000,  // cycles per digit slot, 4..2^20
  parameter int GUARD       = 16      // blanked cycles at slot start, < REFRESH_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cen,
  input  logic [3:0] dec,
  input  logic [3:0] uni,
  input  logic       load,
  input  logic       blank_lz,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       scan_tick
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int CNT_W = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

  // Digit index encoding; IDX_BAD is unreachable and only decoded for recovery.
  localparam logic [1:0] IDX_UNI = 2'd0;
  localparam logic [1:0] IDX_DEC = 2'd1;
  localparam logic [1:0] IDX_CEN = 2'd2;
  localparam logic [1:0] IDX_BAD = 2'd3;

  // Anode patterns (active low): exactly one digit enabled, or none.
  localparam logic [2:0] AN_OFF = 3'b111;
  localparam logic [2:0] AN_UNI = 3'b110;
  localparam logic [2:0] AN_DEC = 3'b101;
  localparam logic [2:0] AN_CEN = 3'b011;

  // Segment patterns {g,f,e,d,c,b,a}, active low.
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // ---------------------------------------------------------------------------
  // Glyph decode: BCD digit to active-low segment pattern, dash for 10..15.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] glyph(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = SEG_DASH;
    endcase
    return pattern;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [3:0]       cen_q;
  logic [3:0]       dec_q;
  logic [3:0]       uni_q;

  logic             slot_wrap;
  logic             cen_zero;
  logic             dec_zero;
  logic             in_guard;
  logic [3:0]       sel_digit;
  logic             sel_blank;
  logic [2:0]       sel_an;
  logic [2:0]       next_an;
  logic [6:0]       next_seg;

  // Capture the converter digits on the load strobe; last strobe wins.
  // NOTE: these are ordinary flops, not a memory array, so they take a reset
  // value; the display then shows a defined "0" after reset instead of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cen_q <= 4'd0;
      dec_q <= 4'd0;
      uni_q <= 4'd0;
    end else if (load) begin
      // NOTE: non-blocking assignments for every registered signal, so all
      // flops sample pre-edge values regardless of statement order.
      cen_q <= cen;
      dec_q <= dec;
      uni_q <= uni;
    end
  end

  // End of slot; ">=" also pulls an out-of-range count back to zero.
  assign slot_wrap = (cnt >= CNT_LAST);

  // Slot counter: 0..REFRESH_DIV-1, then wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (slot_wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Digit index advances units -> tens -> hundreds -> units on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= IDX_UNI;
    end else if (slot_wrap) begin
      case (idx)
        IDX_UNI: idx <= IDX_DEC;
        IDX_DEC: idx <= IDX_CEN;
        default: idx <= IDX_UNI;  // IDX_CEN and the unreachable IDX_BAD
      endcase
    end
  end

  // Leading-zero detection on latched values; a dash digit is nonzero.
  assign cen_zero = (cen_q == 4'd0);
  assign dec_zero = (dec_q == 4'd0);
  assign in_guard = (cnt < CNT_GUARD);

  // Select the digit and anode for the current slot and decide blanking.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the
    // case/if leaves one unassigned and no latch is inferred.
    sel_digit = uni_q;
    sel_blank = 1'b0;
    sel_an    = AN_OFF;
    next_an   = AN_OFF;
    next_seg  = SEG_OFF;

    case (idx)
      IDX_UNI: begin
        sel_digit = uni_q;
        sel_an    = AN_UNI;
      end
      IDX_DEC: begin
        sel_digit = dec_q;
        sel_blank = blank_lz && cen_zero && dec_zero;
        sel_an    = AN_DEC;
      end
      IDX_CEN: begin
        sel_digit = cen_q;
        sel_blank = blank_lz && cen_zero;
        sel_an    = AN_CEN;
      end
      IDX_BAD: begin
        sel_blank = 1'b1;
      end
      default: begin
        sel_blank = 1'b1;
      end
    endcase

    if (!in_guard && !sel_blank) begin
      next_an  = sel_an;
      next_seg = glyph(sel_digit);
    end
  end

  // Register the display outputs and the scan tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an        <= AN_OFF;
      seg       <= SEG_OFF;
      scan_tick <= 1'b0;
    end else begin
      an        <= next_an;
      seg       <= next_seg;
      scan_tick <= slot_wrap;
    end
  end

endmodule

// File: tb/tb_bcd_disp_mux.sv
// Directed testbench for bcd_disp_mux with REFRESH_DIV=8, GUARD=2.
// A free-running edge counter (cyc, cleared by reset) tells the bench which
// slot and slot position the registered outputs currently describe: after
// edge n they reflect count (n-1)%8 of slot ((n-1)/8)%3.

module tb_bcd_disp_mux;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cen = 4'd0;
  logic [3:0] dec = 4'd0;
  logic [3:0] uni = 4'd0;
  logic       load = 1'b0;
  logic       blank_lz = 1'b0;
  logic [2:0] an;
  logic [6:0] seg;
  logic       scan_tick;

  int tests = 0;
  int fails = 0;
  int cyc;

  bcd_disp_mux #(.REFRESH_DIV(DIV), .GUARD(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .dec       (dec),
    .uni       (uni),
    .load      (load),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  // Edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Step at least two negedges, then until outputs describe (slot, pos).
  task automatic go_to(input int slot, input int pos);
    int steps = 0;
    bit hit = 1'b0;
    while (!hit && steps < 64) begin
      @(negedge clk);
      steps++;
      hit = (steps >= 2) && (cyc >= 1) && (((cyc - 1) % DIV) == pos) &&
            ((((cyc - 1) / DIV) % 3) == slot);
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL go_to timeout slot=%0d pos=%0d cyc=%0d", slot, pos, cyc);
    end
  endtask

  task automatic do_load(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
    cen = c; dec = d; uni = u; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (an !== 3'b111 || seg !== 7'b1111111 || scan_tick !== 1'b0) begin
      fails++;
      $display("FAIL reset_state an=%b seg=%b tick=%b exp 111 1111111 0", an, seg, scan_tick);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (an !== 3'b111 || seg !== 7'b1111111) begin
      fails++;
      $display("FAIL reset_first_edge an=%b seg=%b exp 111 1111111", an, seg);
    end
  endtask

  task automatic test_basic();
    blank_lz = 1'b0;
    do_load(4'd2, 4'd5, 4'd5);
    go_to(0, 0);
    tests++;
    if (an !== 3'b111 || seg !== 7'b1111111) begin
      fails++; $display("FAIL basic_guard0 an=%b seg=%b exp 111 1111111", an, seg);
    end
    go_to(0, 1);
    tests++;
    if (an !== 3'b111 || seg !== 7'b1111111) begin
      fails++; $display("FAIL basic_guard1 an=%b seg=%b exp 111 1111111", an, seg);
    end
    go_to(0, 2);
    tests++;
    if (an !== 3'b110 || seg !== 7'b0010010) begin
      fails++; $display("FAIL basic_uni_first an=%b seg=%b exp 110 0010010", an, seg);
    end
    go_to(0, 7);
    tests++;
    if (an !== 3'b110 || seg !== 7'b0010010) begin
      fails++; $display("FAIL basic_uni_last an=%b seg=%b exp 110 0010010", an, seg);
    end
    go_to(1, 2);
    tests++;
    if (an !== 3'b101 || seg !== 7'b0010010) begin
      fails++; $display("FAIL basic_dec an=%b seg=%b exp 101 0010010", an, seg);
    end
    go_to(2, 4);
    tests++;
    if (an !== 3'b011 || seg !== 7'b0100100) begin
      fails++; $display("FAIL basic_cen an=%b seg=%b exp 011 0100100", an, seg);
    end
  endtask

  task automatic test_back_to_back();
    cen = 4'd3; dec = 4'd3; uni = 4'd3; load = 1'b1;
    @(negedge clk);
    cen = 4'd6; dec = 4'd7; uni = 4'd8;
    @(negedge clk);
    load = 1'b0;
    go_to(0, 2);
    tests++;
    if (an !== 3'b110 || seg !== 7'b0000000) begin
      fails++; $display("FAIL b2b_uni an=%b seg=%b exp 110 0000000", an, seg);
    end
    go_to(1, 2);
    tests++;
    if (an !== 3'b101 || seg !== 7'b1111000) begin
      fails++; $display("FAIL b2b_dec an=%b seg=%b exp 101 1111000", an, seg);
    end
    go_to(2, 2);
    tests++;
    if (an !== 3'b011 || seg !== 7'b0000010) begin
      fails++; $display("FAIL b2b_cen an=%b seg=%b exp 011 0000010", an, seg);
    end
  endtask

  task automatic test_blanking();
    blank_lz = 1'b1;
    do_load(4'd0, 4'd0, 4'd7);
    go_to(2, 3);
    tests++;
    if (an !== 3'b111 || seg !== 7'b1111111) begin
      fails++; $display("FAIL blank_cen an=%b seg=%b exp 111 1111111", an, seg);
    end
    go_to(1, 3);
    tests++;
    if (an !== 3'b111 || seg !== 7'b1111111) begin
      fails++; $display("FAIL blank_dec an=%b seg=%b exp 111 1111111", an, seg);
    end
    go_to(0, 3);
    tests++;
    if (an !== 3'b110 || seg !== 7'b1111000) begin
      fails++; $display("FAIL blank_uni an=%b seg=%b exp 110 1111000", an, seg);
    end
    blank_lz = 1'b0;
    go_to(1, 3);
    tests++;
    if (an !== 3'b101 || seg !== 7'b1000000) begin
      fails++; $display("FAIL unblank_dec an=%b seg=%b exp 101 1000000", an, seg);
    end
    go_to(2, 3);
    tests++;
    if (an !== 3'b011 || seg !== 7'b1000000) begin
      fails++; $display("FAIL unblank_cen an=%b seg=%b exp 011 1000000", an, seg);
    end
  endtask

  task automatic test_tens_zero();
    blank_lz = 1'b1;
    do_load(4'd0, 4'd4, 4'd0);
    go_to(2, 5);
    tests++;
    if (an !== 3'b111 || seg !== 7'b1111111) begin
      fails++; $display("FAIL tz_cen an=%b seg=%b exp 111 1111111", an, seg);
    end
    go_to(0, 5);
    tests++;
    if (an !== 3'b110 || seg !== 7'b1000000) begin
      fails++; $display("FAIL tz_uni an=%b seg=%b exp 110 1000000", an, seg);
    end
    go_to(1, 5);
    tests++;
    if (an !== 3'b101 || seg !== 7'b0011001) begin
      fails++; $display("FAIL tz_dec an=%b seg=%b exp 101 0011001", an, seg);
    end
  endtask

  task automatic test_dash();
    blank_lz = 1'b0;
    do_load(4'd1, 4'd2, 4'hC);
    go_to(0, 4);
    tests++;
    if (an !== 3'b110 || seg !== 7'b0111111) begin
      fails++; $display("FAIL dash_uni an=%b seg=%b exp 110 0111111", an, seg);
    end
    blank_lz = 1'b1;
    do_load(4'hF, 4'd0, 4'd0);
    go_to(2, 3);
    tests++;
    if (an !== 3'b011 || seg !== 7'b0111111) begin
      fails++; $display("FAIL dash_cen an=%b seg=%b exp 011 0111111", an, seg);
    end
    go_to(1, 3);
    tests++;
    if (an !== 3'b101 || seg !== 7'b1000000) begin
      fails++; $display("FAIL dash_nonzero_dec an=%b seg=%b exp 101 1000000", an, seg);
    end
    do_load(4'd0, 4'd0, 4'd0);
    go_to(2, 4);
    tests++;
    if (an !== 3'b111 || seg !== 7'b1111111) begin
      fails++; $display("FAIL zero_cen an=%b seg=%b exp 111 1111111", an, seg);
    end
    go_to(1, 4);
    tests++;
    if (an !== 3'b111 || seg !== 7'b1111111) begin
      fails++; $display("FAIL zero_dec an=%b seg=%b exp 111 1111111", an, seg);
    end
    go_to(0, 4);
    tests++;
    if (an !== 3'b110 || seg !== 7'b1000000) begin
      fails++; $display("FAIL zero_uni an=%b seg=%b exp 110 1000000", an, seg);
    end
  endtask

  task automatic test_scan();
    logic [2:0] exp_an [3];
    int ticks = 0;
    exp_an[0] = 3'b110; exp_an[1] = 3'b101; exp_an[2] = 3'b011;
    blank_lz = 1'b0;
    do_load(4'd1, 4'd2, 4'd3);
    go_to(0, 0);
    for (int i = 0; i < 3 * DIV; i++) begin
      int p;
      int s;
      logic exp_tick;
      @(negedge clk);
      p = (cyc - 1) % DIV;
      s = ((cyc - 1) / DIV) % 3;
      exp_tick = (p == DIV - 1);
      if (scan_tick === 1'b1) ticks++;
      tests++;
      if (scan_tick !== exp_tick) begin
        fails++; $display("FAIL scan_tick cyc=%0d got=%b exp=%b", cyc, scan_tick, exp_tick);
      end
      if (p == 3) begin
        tests++;
        if (an !== exp_an[s]) begin
          fails++; $display("FAIL scan_an slot=%0d got=%b exp=%b", s, an, exp_an[s]);
        end
      end
    end
    tests++;
    if (ticks != 3) begin
      fails++; $display("FAIL scan_tick_count got=%0d exp=3", ticks);
    end
    cen = 4'd9; dec = 4'd9; uni = 4'd9;
    go_to(0, 3);
    tests++;
    if (an !== 3'b110 || seg !== 7'b0110000) begin
      fails++; $display("FAIL noload_uni an=%b seg=%b exp 110 0110000", an, seg);
    end
    go_to(1, 3);
    tests++;
    if (an !== 3'b101 || seg !== 7'b0100100) begin
      fails++; $display("FAIL noload_dec an=%b seg=%b exp 101 0100100", an, seg);
    end
    go_to(2, 3);
    tests++;
    if (an !== 3'b011 || seg !== 7'b1111001) begin
      fails++; $display("FAIL noload_cen an=%b seg=%b exp 011 1111001", an, seg);
    end
  endtask

  task automatic test_reset_mid();
    go_to(1, 4);
    tests++;
    if (an !== 3'b101) begin
      fails++; $display("FAIL pre_reset_dec an=%b exp 101", an);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (an !== 3'b111 || seg !== 7'b1111111 || scan_tick !== 1'b0) begin
      fails++; $display("FAIL async_reset an=%b seg=%b tick=%b exp 111 1111111 0", an, seg, scan_tick);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      logic [2:0] ea;
      logic [6:0] es;
      @(negedge clk);
      ea = (k < 3) ? 3'b111 : 3'b110;
      es = (k < 3) ? 7'b1111111 : 7'b1000000;
      tests++;
      if (an !== ea || seg !== es) begin
        fails++; $display("FAIL post_reset k=%0d an=%b seg=%b exp %b %b", k, an, seg, ea, es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_blanking();
    test_tens_zero();
    test_dash();
    test_scan();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_disp_mux.md
Name: bcd_disp_mux

Overview:
- Downstream consumer of the 8-bit binary-to-BCD converter: takes its hundreds/tens/units digits and drives a 3-digit, common-anode, time-multiplexed 7-segment display.
- Latches the digits on a load strobe, so converter outputs may change freely between loads.
- Provides a programmable refresh rate, an anti-ghosting guard interval, optional leading-zero blanking and a dash glyph for out-of-range (>9) digits.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot (1 kHz per digit at 50 MHz); legal range 4..2^20.
- GUARD, 16: cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- cen  in  4  hundreds BCD digit.
- dec  in  4  tens BCD digit.
- uni  in  4  units BCD digit.
- load  in  1  one-cycle strobe; captures cen/dec/uni.
- blank_lz  in  1  1 = blank leading zeros.
- an  out  3  anode enables, active low; an[0]=units, an[1]=tens, an[2]=hundreds.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- scan_tick  out  1  one-cycle pulse when the digit index advances.

Behaviour:
- Reset (async assert, sync release):
  - cnt=0, idx=0 (units), latched digits = 0.
  - an=3'b111, seg=7'b1111111, scan_tick=0.
- Load: when load=1 at an edge, the latches take cen/dec/uni at that edge. The new value drives seg from the next output update (1-cycle latency). Back-to-back loads are allowed; the last one wins. Load during the guard interval or at a slot boundary is accepted normally.
- Slot counter: cnt counts 0..REFRESH_DIV-1 and wraps to 0. On wrap, idx advances 0->1->2->0, and scan_tick=1 on that same edge (registered, high for exactly one cycle).
- Outputs are registered and computed from the pre-edge cnt/idx/latches, so outputs lag state by 1 cycle.
  - cnt < GUARD: an=3'b111 and seg=7'b1111111.
  - Otherwise: an = all ones except bit idx = 0; seg = glyph of the selected latched digit.
- Glyphs (active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = dash 0111111.
- Leading-zero blanking (blank_lz=1), evaluated on latched values:
  - Hundreds blank if cen==0.
  - Tens blank if cen==0 and dec==0.
  - Units never blank.
  - A blanked digit drives seg=7'b1111111 and keeps its anode off (all ones) for the whole slot.
  - A dash (non-BCD) digit counts as nonzero.
- blank_lz is sampled live with no latch; a change takes effect on the next output update.
- Reset mid-scan: everything returns to reset values immediately. After release, the scan restarts at units with a full guard interval.
- No handshake back to the converter: load is fire-and-forget and always accepted.
- Counter width: clog2(REFRESH_DIV). Idx value 3 is unreachable; if forced, it recovers to 0 on the next wrap with anodes all off.

Test Plan:
(REFRESH_DIV=8, GUARD=2 for simulation.)
1. Reset, then load cen=2, dec=5, uni=5, blank_lz=0 -> units slot: an=110 with seg=0010010 from cycle 3 to cycle 8 of the slot (anodes off for cycles 1-2); tens the same glyph with an=101; hundreds seg=0100100 with an=011.
2. Load 0/0/7 with blank_lz=1 -> hundreds and tens slots show an=111, seg=1111111; units slot shows seg=1111000, an=110. Clear blank_lz -> hundreds and tens show 1000000.
3. Load 0/4/0 with blank_lz=1 -> hundreds blank; tens=0011001; units=1000000 (not blanked).
4. Load uni=4'hC -> units slot seg=0111111. Load 0/0/0 with blank_lz=1 -> only units lit, seg=1000000.
5. Free-run 3 full scans -> scan_tick pulses every 8 cycles, 1 cycle wide; idx sequence 0,1,2,0. Change cen/dec/uni with no load -> display unchanged.
6. Assert rst_n low mid-slot of tens -> an=111, seg=1111111 in the same cycle without a clock edge. After release, the first lit anode is units, at cycle 3.
